// File: rtl/msdf_test_pkg.sv
// rtl/msdf_test_pkg.sv - shared register map, bit positions and FSM states for the MSDF adder test controller
package msdf_test_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_X      = 3'd2;
    localparam logic [2:0] ADDR_Y      = 3'd3;
    localparam logic [2:0] ADDR_Z      = 3'd4;
    localparam logic [2:0] ADDR_CYCLES = 3'd5;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_ERROR_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/msdf_digit_serializer.sv
// rtl/msdf_digit_serializer.sv - loads X/Y operands and shifts them out MSD-first with zero padding
module msdf_digit_serializer #(
    parameter int DIGIT_W  = 3,
    parameter int N_DIGITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         advance,
    input  logic                         stop,
    input  logic [DIGIT_W*N_DIGITS-1:0]  x_word,
    input  logic [DIGIT_W*N_DIGITS-1:0]  y_word,
    output logic [DIGIT_W-1:0]           x_digit,
    output logic [DIGIT_W-1:0]           y_digit,
    output logic                         digit_valid,
    output logic                         first_digit
);

    localparam int W = DIGIT_W * N_DIGITS;

    logic [W-1:0] x_sh;
    logic [W-1:0] y_sh;

    // Zeros shift in behind the operand, so flush digits come out as 0 for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sh        <= '0;
            y_sh        <= '0;
            x_digit     <= '0;
            y_digit     <= '0;
            digit_valid <= 1'b0;
            first_digit <= 1'b0;
        end else if (load) begin
            x_digit     <= x_word[W-1 -: DIGIT_W];
            y_digit     <= y_word[W-1 -: DIGIT_W];
            x_sh        <= x_word << DIGIT_W;
            y_sh        <= y_word << DIGIT_W;
            digit_valid <= 1'b1;
            first_digit <= 1'b1;
        end else if (stop) begin
            x_sh        <= '0;
            y_sh        <= '0;
            x_digit     <= '0;
            y_digit     <= '0;
            digit_valid <= 1'b0;
            first_digit <= 1'b0;
        end else if (advance) begin
            x_digit     <= x_sh[W-1 -: DIGIT_W];
            y_digit     <= y_sh[W-1 -: DIGIT_W];
            x_sh        <= x_sh << DIGIT_W;
            y_sh        <= y_sh << DIGIT_W;
            first_digit <= 1'b0;
        end
    end

endmodule

// File: rtl/msdf_adder_test_ctrl.sv
// rtl/msdf_adder_test_ctrl.sv - HPS-facing test controller driving and collecting an MSDF adder
module msdf_adder_test_ctrl
    import msdf_test_pkg::*;
#(
    parameter int DIGIT_W       = 3,
    parameter int N_DIGITS      = 8,
    parameter int ONLINE_DELAY  = 2,
    parameter int TIMEOUT_SLACK = 8
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [2:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic [DIGIT_W-1:0] x_digit,
    output logic [DIGIT_W-1:0] y_digit,
    output logic               digit_valid,
    output logic               first_digit,
    input  logic [DIGIT_W-1:0] z_digit,
    input  logic               z_valid
);

    localparam int OP_W  = DIGIT_W * N_DIGITS;
    localparam int Z_W   = (N_DIGITS + 1) * DIGIT_W;
    localparam int CNT_W = $clog2(N_DIGITS + 2);
    localparam int IDX_W = $clog2(N_DIGITS + 1);
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(N_DIGITS + ONLINE_DELAY + TIMEOUT_SLACK);

    state_t            state;
    state_t            state_next;
    logic [OP_W-1:0]   x_reg;
    logic [OP_W-1:0]   y_reg;
    logic [Z_W-1:0]    z_reg;
    logic [CNT_W-1:0]  res_cnt;
    logic [IDX_W-1:0]  feed_idx;
    logic [15:0]       cycles;
    logic [15:0]       cycles_inc;
    logic              error_flag;

    logic              ctrl_wr;
    logic              start_req;
    logic              clear_req;
    logic              busy;
    logic              capture;
    logic              completing;
    logic              timeout_hit;
    logic              begin_op;
    logic              ser_load;
    logic              ser_adv;
    logic              ser_stop;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign unused_wdata = ^avs_writedata;

    // Clear takes priority over start when both bits arrive in one write.
    assign ctrl_wr     = avs_write && (avs_address == ADDR_CTRL);
    assign clear_req   = ctrl_wr && avs_writedata[CTRL_CLEAR_BIT];
    assign start_req   = ctrl_wr && avs_writedata[CTRL_START_BIT] && !avs_writedata[CTRL_CLEAR_BIT];

    assign busy        = (state == ST_FEED) || (state == ST_FLUSH);
    assign capture     = busy && z_valid;
    assign completing  = capture && (res_cnt == CNT_W'(N_DIGITS));
    assign cycles_inc  = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
    assign timeout_hit = busy && !completing && (cycles_inc == TIMEOUT_LIMIT);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ser_load   = 1'b0;
        ser_adv    = 1'b0;
        ser_stop   = 1'b0;
        begin_op   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_next = ST_FEED;
                    ser_load   = 1'b1;
                    begin_op   = 1'b1;
                end
            end
            ST_FEED: begin
                ser_adv = 1'b1;
                if (completing || timeout_hit) begin
                    state_next = ST_DONE;
                    ser_stop   = 1'b1;
                end else if (feed_idx == IDX_W'(N_DIGITS - 1)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                ser_adv = 1'b1;
                if (completing || timeout_hit) begin
                    state_next = ST_DONE;
                    ser_stop   = 1'b1;
                end
            end
            ST_DONE: begin
                if (clear_req) begin
                    state_next = ST_IDLE;
                end else if (start_req) begin
                    state_next = ST_FEED;
                    ser_load   = 1'b1;
                    begin_op   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            x_reg      <= '0;
            y_reg      <= '0;
            z_reg      <= '0;
            res_cnt    <= '0;
            feed_idx   <= '0;
            cycles     <= '0;
            error_flag <= 1'b0;
        end else begin
            if (avs_write && !busy && (avs_address == ADDR_X)) begin
                x_reg <= avs_writedata[OP_W-1:0];
            end
            if (avs_write && !busy && (avs_address == ADDR_Y)) begin
                y_reg <= avs_writedata[OP_W-1:0];
            end

            if (begin_op) begin
                z_reg      <= '0;
                res_cnt    <= '0;
                feed_idx   <= '0;
                cycles     <= '0;
                error_flag <= 1'b0;
            end else if (busy) begin
                // The completing cycle is itself counted, so CYCLES is inclusive.
                cycles <= cycles_inc;
                if (capture) begin
                    z_reg   <= {z_reg[Z_W-DIGIT_W-1:0], z_digit};
                    res_cnt <= res_cnt + 1'b1;
                end
                if (timeout_hit) begin
                    error_flag <= 1'b1;
                end
                if ((state == ST_FEED) && (feed_idx != IDX_W'(N_DIGITS - 1))) begin
                    feed_idx <= feed_idx + 1'b1;
                end
            end else if ((state == ST_DONE) && clear_req) begin
                error_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY_BIT]  = busy;
                rd_mux[STAT_DONE_BIT]  = (state == ST_DONE);
                rd_mux[STAT_ERROR_BIT] = error_flag;
            end
            ADDR_X:      rd_mux = 32'(x_reg);
            ADDR_Y:      rd_mux = 32'(y_reg);
            ADDR_Z:      rd_mux = 32'(z_reg);
            ADDR_CYCLES: rd_mux = 32'(cycles);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    msdf_digit_serializer #(
        .DIGIT_W  (DIGIT_W),
        .N_DIGITS (N_DIGITS)
    ) u_serializer (
        .clk         (clk_clk),
        .rst         (reset_reset),
        .load        (ser_load),
        .advance     (ser_adv),
        .stop        (ser_stop),
        .x_word      (x_reg),
        .y_word      (y_reg),
        .x_digit     (x_digit),
        .y_digit     (y_digit),
        .digit_valid (digit_valid),
        .first_digit (first_digit)
    );

endmodule

// File: tb/tb_msdf_adder_test_ctrl.sv
// tb/tb_msdf_adder_test_ctrl.sv - self-checking bench for msdf_adder_test_ctrl with a 2-cycle loopback adder
module tb_msdf_adder_test_ctrl;

    localparam int DW         = 3;
    localparam int ND         = 8;
    localparam int LOOP_DELAY = 2;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic [2:0]  x_digit;
    logic [2:0]  y_digit;
    logic        digit_valid;
    logic        first_digit;
    logic [2:0]  z_digit;
    logic        z_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic       loop_en = 1'b1;
    logic [2:0] d1_d, d2_d;
    logic       d1_v, d2_v;

    logic [2:0] xq[$];
    logic [2:0] yq[$];
    bit         fq[$];

    msdf_adder_test_ctrl dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .x_digit       (x_digit),
        .y_digit       (y_digit),
        .digit_valid   (digit_valid),
        .first_digit   (first_digit),
        .z_digit       (z_digit),
        .z_valid       (z_valid)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            d1_d <= '0; d2_d <= '0; d1_v <= 1'b0; d2_v <= 1'b0;
        end else begin
            d1_d <= x_digit; d2_d <= d1_d;
            d1_v <= digit_valid; d2_v <= d1_v;
        end
    end
    assign z_digit = d2_d;
    assign z_valid = loop_en & d2_v;

    always @(negedge clk_clk) begin
        if (digit_valid) begin
            xq.push_back(x_digit);
            yq.push_back(y_digit);
            fq.push_back(first_digit);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Result the loopback adder should produce: the X digits MSD-first, then one flush zero.
    function automatic logic [31:0] model_z(input logic [23:0] x);
        logic [31:0] z = 0;
        for (int i = 0; i <= ND; i++) begin
            int d = (i < ND) ? int'((x >> (DW * (ND - 1 - i))) % 8) : 0;
            z = z * 8 + 32'(d);
        end
        return z;
    endfunction

    function automatic logic [2:0] digit_of(input logic [23:0] w, input int i);
        return 3'((w >> (DW * (ND - 1 - i))) % 8);
    endfunction

    task automatic avs_wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(posedge clk_clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(posedge clk_clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wait_done(output logic [31:0] st);
        st = 0;
        for (int i = 0; i < 60; i++) begin
            avs_rd(3'd1, st);
            if (st[1]) break;
        end
        n_checks++;
        if (!st[1]) begin
            n_fail++;
            $display("FAIL wait_done: status=0x%0h, done bit never set", st);
        end
    endtask

    task automatic clear_queues();
        xq.delete(); yq.delete(); fq.delete();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        n_checks++;
        if ({x_digit, y_digit, digit_valid, first_digit} !== 8'h0 || avs_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: x=%0h y=%0h v=%0b f=%0b rd=%0h, want all 0",
                     x_digit, y_digit, digit_valid, first_digit, avs_readdata);
        end
        for (int a = 1; a <= 5; a++) begin
            avs_rd(3'(a), r);
            n_checks++;
            if (r !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got 0x%0h want 0x0", a, r);
            end
        end
        avs_wr(3'd2, 32'h777777);
        avs_wr(3'd0, 32'h1);
        avs_rd(3'd2, r);
        @(posedge clk_clk); #2;
        reset_reset = 1'b1;
        #1;
        n_checks++;
        if ({x_digit, y_digit, digit_valid, first_digit} !== 8'h0 || avs_readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_midop: x=%0h y=%0h v=%0b f=%0b rd=%0h, want all 0",
                     x_digit, y_digit, digit_valid, first_digit, avs_readdata);
        end
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        avs_rd(3'd1, r);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: got 0x%0h want 0x0", r);
        end
        avs_rd(3'd2, r);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_x: got 0x%0h want 0x0", r);
        end
    endtask

    task automatic test_loopback();
        logic [31:0] r;
        int bad = 0, firsts = 0;
        avs_wr(3'd2, 32'h249249);
        avs_wr(3'd3, 32'h0);
        clear_queues();
        avs_wr(3'd0, 32'h1);
        avs_rd(3'd1, r);
        n_checks++;
        if (r !== 32'h1) begin
            n_fail++;
            $display("FAIL loop_busy: status=0x%0h want 0x1", r);
        end
        wait_done(r);
        n_checks++;
        if (r !== 32'h2) begin
            n_fail++;
            $display("FAIL loop_status: status=0x%0h want 0x2", r);
        end
        avs_rd(3'd4, r);
        n_checks++;
        if (r !== 32'h1249248 || r !== model_z(24'h249249)) begin
            n_fail++;
            $display("FAIL loop_z: got 0x%0h want 0x1249248", r);
        end
        avs_rd(3'd5, r);
        n_checks++;
        if (r !== 32'(ND + LOOP_DELAY + 1)) begin
            n_fail++;
            $display("FAIL loop_cycles: got %0d want %0d", r, ND + LOOP_DELAY + 1);
        end
        n_checks++;
        if (xq.size() != ND + LOOP_DELAY + 1) begin
            n_fail++;
            $display("FAIL loop_valid_cycles: got %0d want %0d", xq.size(), ND + LOOP_DELAY + 1);
        end else begin
            foreach (xq[i]) begin
                if (xq[i] !== ((i < ND) ? 3'd1 : 3'd0) || yq[i] !== 3'd0) bad++;
                if (fq[i]) firsts++;
            end
            if (bad != 0 || firsts != 1 || !fq[0]) begin
                n_fail++;
                $display("FAIL loop_stream: %0d bad digits, %0d first flags (want 0, 1)", bad, firsts);
            end
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] r;
        clear_queues();
        avs_wr(3'd0, 32'h1);
        avs_wr(3'd2, 32'hFFFFFF);
        avs_wr(3'd0, 32'h1);
        avs_rd(3'd2, r);
        n_checks++;
        if (r !== 32'h249249) begin
            n_fail++;
            $display("FAIL busy_x: got 0x%0h want 0x249249", r);
        end
        wait_done(r);
        avs_rd(3'd4, r);
        n_checks++;
        if (r !== 32'h1249248) begin
            n_fail++;
            $display("FAIL busy_z: got 0x%0h want 0x1249248", r);
        end
        avs_rd(3'd5, r);
        n_checks++;
        if (r !== 32'd11 || xq.size() != 11) begin
            n_fail++;
            $display("FAIL busy_cycles: cycles=%0d valid=%0d want 11, 11", r, xq.size());
        end
    endtask

    task automatic test_timeout();
        logic [31:0] r;
        loop_en = 1'b0;
        clear_queues();
        avs_wr(3'd0, 32'h1);
        wait_done(r);
        n_checks++;
        if (r !== 32'h6) begin
            n_fail++;
            $display("FAIL timeout_status: got 0x%0h want 0x6", r);
        end
        avs_rd(3'd5, r);
        n_checks++;
        if (r !== 32'd18 || xq.size() != 18) begin
            n_fail++;
            $display("FAIL timeout_cycles: cycles=%0d valid=%0d want 18, 18", r, xq.size());
        end
        loop_en = 1'b1;
    endtask

    task automatic test_clear_restart();
        logic [31:0] r;
        logic [23:0] x2 = 24'h5A5A5A;
        avs_wr(3'd0, 32'h3);
        avs_rd(3'd1, r);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_status: got 0x%0h want 0x0", r);
        end
        avs_wr(3'd2, 32'h249249);
        avs_wr(3'd0, 32'h1);
        wait_done(r);
        avs_wr(3'd0, 32'h3);
        avs_rd(3'd1, r);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL clear2_status: got 0x%0h want 0x0", r);
        end
        avs_wr(3'd2, 32'(x2));
        avs_wr(3'd0, 32'h1);
        avs_rd(3'd4, r);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL restart_zclear: got 0x%0h want 0x0", r);
        end
        wait_done(r);
        avs_rd(3'd4, r);
        n_checks++;
        if (r !== model_z(x2)) begin
            n_fail++;
            $display("FAIL restart_z: got 0x%0h want 0x%0h", r, model_z(x2));
        end
    endtask

    task automatic test_register_reads();
        logic [31:0] r;
        avs_wr(3'd2, 32'h0ABCDE);
        avs_wr(3'd3, 32'h654321);
        avs_wr(3'd6, 32'hDEADBEEF);
        for (int a = 6; a <= 8; a++) begin
            avs_rd(3'(a), r);
            n_checks++;
            if (r !== 32'h0) begin
                n_fail++;
                $display("FAIL unmapped_rd%0d: got 0x%0h want 0x0", a % 8, r);
            end
        end
        avs_address = 3'd2; avs_read = 1'b1;
        @(posedge clk_clk); #1;
        n_checks++;
        if (avs_readdata !== 32'h0ABCDE) begin
            n_fail++;
            $display("FAIL b2b_x: got 0x%0h want 0xabcde", avs_readdata);
        end
        avs_address = 3'd3;
        @(posedge clk_clk); #1;
        avs_read = 1'b0;
        n_checks++;
        if (avs_readdata !== 32'h654321) begin
            n_fail++;
            $display("FAIL b2b_y: got 0x%0h want 0x654321", avs_readdata);
        end
        avs_address = 3'd2;
        repeat (3) @(posedge clk_clk);
        #1;
        n_checks++;
        if (avs_readdata !== 32'h654321) begin
            n_fail++;
            $display("FAIL rd_hold: got 0x%0h want 0x654321", avs_readdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [23:0] x, y;
        for (int k = 0; k < 5; k++) begin
            int bad = 0, firsts = 0;
            x = 24'($urandom);
            y = 24'($urandom);
            avs_wr(3'd2, 32'(x));
            avs_wr(3'd3, 32'(y));
            clear_queues();
            avs_wr(3'd0, 32'h1);
            wait_done(r);
            avs_rd(3'd4, r);
            n_checks++;
            if (r !== model_z(x)) begin
                n_fail++;
                $display("FAIL rand_z[%0d]: x=0x%0h got 0x%0h want 0x%0h", k, x, r, model_z(x));
            end
            avs_rd(3'd5, r);
            n_checks++;
            if (r !== 32'(ND + LOOP_DELAY + 1)) begin
                n_fail++;
                $display("FAIL rand_cycles[%0d]: got %0d want %0d", k, r, ND + LOOP_DELAY + 1);
            end
            n_checks++;
            if (xq.size() != ND + LOOP_DELAY + 1) begin
                n_fail++;
                $display("FAIL rand_len[%0d]: got %0d want %0d", k, xq.size(), ND + LOOP_DELAY + 1);
            end else begin
                foreach (xq[i]) begin
                    if (xq[i] !== ((i < ND) ? digit_of(x, i) : 3'd0)) bad++;
                    if (yq[i] !== ((i < ND) ? digit_of(y, i) : 3'd0)) bad++;
                    if (fq[i]) firsts++;
                end
                if (bad != 0 || firsts != 1 || !fq[0]) begin
                    n_fail++;
                    $display("FAIL rand_stream[%0d]: %0d bad digits, %0d first flags", k, bad, firsts);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        test_reset();
        test_loopback();
        test_busy_writes();
        test_timeout();
        test_clear_restart();
        test_register_reads();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msdf_adder_test_ctrl.md
# msdf_adder_test_ctrl

HPS-facing test controller for the MSDF adder under test. Sits directly downstream of the `soc_system` platform: the HPS writes operands over an exported Avalon-MM slave and issues start. The block streams signed digits MSD-first into the adder, collects its result digits and exposes result, status and cycle count for readback. It runs in the `clk_clk` domain with the platform reset.

## Interface

Parameters:
- `DIGIT_W`, 3: bits per two's-complement signed digit (radix 2^(DIGIT_W-1)).
- `N_DIGITS`, 8: operand digits. Constraint: (N_DIGITS+1)*DIGIT_W ≤ 32.
- `ONLINE_DELAY`, 2: adder online delay. Used only for the timeout.
- `TIMEOUT_SLACK`, 8: extra cycles allowed before error.

Ports:
- `clk_clk`  in  1: clock; the only clock.
- `reset_reset`  in  1: reset, asynchronous, active-high.
- `avs_address`  in  3: word address.
- `avs_read`  in  1: read strobe.
- `avs_write`  in  1: write strobe.
- `avs_writedata`  in  32: write data.
- `avs_readdata`  out  32: read data, registered.
- `x_digit`  out  DIGIT_W: operand X digit.
- `y_digit`  out  DIGIT_W: operand Y digit.
- `digit_valid`  out  1: X and Y digits valid this cycle.
- `first_digit`  out  1: marks the MSD of a new operation.
- `z_digit`  in  DIGIT_W: result digit from the adder.
- `z_valid`  in  1: `z_digit` valid.

## Operation

Register map (word addresses):
- 0 CTRL (W): bit0 start, bit1 clear. Reads as 0.
- 1 STATUS (R): bit0 busy, bit1 done, bit2 error.
- 2 X (R/W).
- 3 Y (R/W).
- 4 Z (R): result, right-aligned, (N_DIGITS+1)*DIGIT_W bits, zero-extended.
- 5 CYCLES (R): 16-bit count, zero-extended.
- Unmapped addresses read 0; writes to them are ignored.

FSM states are IDLE, FEED, FLUSH, DONE.

- **IDLE**
  - Start → FEED. On entry, clear Z, the result count, CYCLES and error.
- **FEED**
  - Digit i (i = 0..N_DIGITS-1) drives `x_digit` = X[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W]; same slicing for Y.
  - `digit_valid` is high; `first_digit` is high for i = 0 only.
  - After digit N_DIGITS-1 → FLUSH.
- **FLUSH**
  - `digit_valid` stays high with zero digits.
- **Collection** (FEED and FLUSH)
  - Each `z_valid` cycle does Z ← (Z << DIGIT_W) | z_digit and increments the result count.
  - When the count reaches N_DIGITS+1 → DONE.
- **Timeout**
  - A cycle counter starts at the first FEED cycle.
  - If it reaches N_DIGITS+ONLINE_DELAY+TIMEOUT_SLACK without completion: set error, → DONE.
- **DONE**
  - done=1; outputs idle.
  - Clear → IDLE and clears done and error.
  - Start → FEED as a restart, with the same clears as from IDLE.
- **busy** = 1 in FEED and FLUSH.

Boundary rules:
- Start while busy: ignored.
- X/Y writes while busy: ignored.
- Start and clear in the same write: clear wins; start is ignored.
- `z_valid` outside FEED/FLUSH: ignored.
- `z_valid` in the same cycle as the completing count: that digit is captured, then the state moves to DONE.
- CYCLES counts from the first FEED cycle through the cycle of the final captured digit, inclusive. It saturates at 0xFFFF.
- Reset asserted mid-operation: immediate return to IDLE.

## Timing

- Reset values: `avs_readdata`=0, `x_digit`=0, `y_digit`=0, `digit_valid`=0, `first_digit`=0. X, Y, Z, CYCLES and STATUS all 0.
- A start write accepted at edge t puts the FSM in FEED after t. MSD digits appear on the outputs in the cycle following the write.
- Operand outputs are registered from the FSM state.
- `z_digit`/`z_valid` are sampled on the clock edge.
- Read latency is 1 cycle: `avs_readdata` is valid the cycle after `avs_read`.
- No waitrequest; every access completes immediately.
- `avs_readdata` holds its value when not reading.
- The STATUS done bit is visible on a read issued in the cycle after the final digit is captured.

## Structure

- Shared package `msdf_test_pkg`:
  - register address constants (CTRL, STATUS, X, Y, Z, CYCLES);
  - CTRL/STATUS bit positions;
  - FSM state enum.
- One natural sub-module: `msdf_digit_serializer`, which loads X/Y and shifts out MSD-first with `first_digit` and zero padding.
- The Avalon decode, FSM, collector and counters stay in the top level.

## Test plan

All cases use default parameters. The bench loopback drives `z_digit` = `x_digit` delayed 2 cycles and `z_valid` = `digit_valid` delayed 2 cycles.

1. **Reset:** assert `reset_reset` asynchronously mid-cycle → all outputs 0 immediately; STATUS reads 0.
2. **Loopback operation:** X=0x249249, Y=0x0, start → 8 FEED digits of 1, `first_digit` high once. STATUS goes 0x1, then 0x2. Z=0x1249248 (X<<3). CYCLES=11.
3. **Writes while busy:** start then, during FEED, write X=0xFFFFFF and start again → X reads back 0x249249 and the operation is unaffected.
4. **Timeout:** `z_valid` tied low, start → DONE after 18 cycles; STATUS=0x6.
5. **Clear and restart:** from DONE, write CTRL=0x3 → IDLE, STATUS=0. Then write CTRL=0x1 → new operation; Z is cleared before capture.
6. **Register reads:** read addresses 6 and 7 → 0. Back-to-back reads of 2 then 3 → one-cycle latency each, with correct X and Y values.
